// File: rtl/data_mem_axi_bridge.sv
// data_mem_axi_bridge
//   Bridges the CPU data-memory request FSM (level request / pulse ready
//   handshake) onto single-beat AXI4 read and write transactions toward DDR.
//   Only one transaction is outstanding at any time.
//
// Parameters
//   ADDR_W          request / AXI address width
//   ERR_ON_MISALIGN 1: an access whose address is not a multiple of its size
//                   completes immediately with resp_error and no AXI traffic
//
// Optional build macro
//   DATA_MEM_AXI_TIMEOUT_EN  adds a 16-bit watchdog on every AXI wait state;
//                            on expiry the request completes with resp_error.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   address_to_mem                byte address of the request
//   read_request_to_mem           level read request (wins over write)
//   write_request_to_mem          level write request
//   size_select_to_mem            00=1B 01=2B 10=4B 11=8B
//   write_data_to_mem             LSB-aligned write data, valid in the capture cycle
//   read_data_from_mem            zero-extended read data, held until the next read
//   read_ready_from_mem           one-cycle pulse: read finished
//   write_ready_from_mem          one-cycle pulse: write data will be captured next cycle
//   write_finished_from_mem       one-cycle pulse: write finished
//   resp_error                    pulse alongside read_ready / write_finished on error
//   m_axi_*                       AXI4 master read/write channels (single beat)

module data_mem_axi_bridge #(
    parameter int ADDR_W          = 64,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_to_mem,
    input  logic              read_request_to_mem,
    input  logic              write_request_to_mem,
    input  logic [1:0]        size_select_to_mem,
    input  logic [63:0]       write_data_to_mem,
    output logic [63:0]       read_data_from_mem,
    output logic              read_ready_from_mem,
    output logic              write_ready_from_mem,
    output logic              write_finished_from_mem,
    output logic              resp_error,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arsize,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [63:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    output logic              m_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awsize,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [63:0]       m_axi_wdata,
    output logic [7:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [3:0] {
        IDLE, RD_ADDR, RD_DATA, RD_DONE,
        WR_ACK, WR_CAPT, WR_XFER, WR_RESP, WR_DONE,
        ERR_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              is_wr_q, is_wr_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;
    logic              rd_rdy_q, rd_rdy_d;
    logic              wr_fin_q, wr_fin_d;
    logic              err_q, err_d;
    logic              tmo_hit;

    // Single-beat transfers: rlast carries no information.
    logic unused_rlast;
    assign unused_rlast = m_axi_rlast;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Misaligned when any address bit below the access size is set.
    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] sz);
        logic [2:0] low_bits;
        case (sz)
            2'b00:   low_bits = 3'b000;
            2'b01:   low_bits = 3'b001;
            2'b10:   low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return |(lo & low_bits);
    endfunction

`ifdef DATA_MEM_AXI_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        in_wait;

    assign in_wait = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                     (state_q == WR_XFER) || (state_q == WR_RESP);
    assign tmo_hit = in_wait && (tmo_q == 16'hFFFF);

    // Restarts on every state change so each wait state gets a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_d != state_q || !in_wait) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        is_wr_d   = is_wr_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rd_rdy_d  = 1'b0;
        wr_fin_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_request_to_mem || write_request_to_mem) begin
                    addr_d  = address_to_mem;
                    size_d  = size_select_to_mem;
                    is_wr_d = !read_request_to_mem;
                    if (ERR_ON_MISALIGN &&
                        is_misaligned(address_to_mem[2:0], size_select_to_mem)) begin
                        state_d  = ERR_DONE;
                        err_d    = 1'b1;
                        rd_rdy_d = read_request_to_mem;
                        wr_fin_d = !read_request_to_mem;
                    end else begin
                        state_d = read_request_to_mem ? RD_ADDR : WR_ACK;
                    end
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end else if (tmo_hit) begin
                    state_d  = RD_DONE;
                    rd_rdy_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_d  = (m_axi_rdata >> {addr_q[2:0], 3'b000}) & size_mask(size_q);
                    rd_rdy_d = 1'b1;
                    err_d    = (m_axi_rresp != 2'b00);
                    state_d  = RD_DONE;
                end else if (tmo_hit) begin
                    state_d  = RD_DONE;
                    rd_rdy_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            RD_DONE: begin
                // Wait for the request to drop so a held request is not re-issued.
                if (!read_request_to_mem) state_d = IDLE;
            end
            WR_ACK: state_d = WR_CAPT;
            WR_CAPT: begin
                wdata_d   = write_data_to_mem << {addr_q[2:0], 3'b000};
                wstrb_d   = size_strb(size_q) << addr_q[2:0];
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                state_d   = WR_XFER;
            end
            WR_XFER: begin
                // AW and W retire independently, in either order.
                if (m_axi_awready) aw_pend_d = 1'b0;
                if (m_axi_wready)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_RESP;
                end else if (tmo_hit) begin
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    state_d   = WR_DONE;
                    wr_fin_d  = 1'b1;
                    err_d     = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    wr_fin_d = 1'b1;
                    err_d    = (m_axi_bresp != 2'b00);
                    state_d  = WR_DONE;
                end else if (tmo_hit) begin
                    wr_fin_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = WR_DONE;
                end
            end
            WR_DONE: begin
                if (!write_request_to_mem) state_d = IDLE;
            end
            ERR_DONE: begin
                if (is_wr_q ? !write_request_to_mem : !read_request_to_mem) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            is_wr_q   <= 1'b0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rd_rdy_q  <= 1'b0;
            wr_fin_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            is_wr_q   <= is_wr_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rd_rdy_q  <= rd_rdy_d;
            wr_fin_q  <= wr_fin_d;
            err_q     <= err_d;
        end
    end

    assign read_data_from_mem      = rdata_q;
    assign read_ready_from_mem     = rd_rdy_q;
    assign write_finished_from_mem = wr_fin_q;
    assign resp_error              = err_q;
    assign write_ready_from_mem    = (state_q == WR_ACK);

    assign m_axi_araddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign m_axi_awaddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign m_axi_arsize  = {1'b0, size_q};
    assign m_axi_awsize  = {1'b0, size_q};
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awvalid = (state_q == WR_XFER) && aw_pend_q;
    assign m_axi_wvalid  = (state_q == WR_XFER) && w_pend_q;
    assign m_axi_wlast   = m_axi_wvalid;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == WR_RESP);

endmodule
